rv32i_regfile: RTL and testbench

//  RV32I integer register file: 32 x 32-bit architectural registers x0..x31.
//  - Two combinational read ports (rs1/rs2 operands), one synchronous write port (rd writeback).
//  - Sits in the decode/writeback path of the single-issue core.
//  - x0 is hardwired to zero.

---
 rtl/rv32i_pkg.sv | 11 +
 rtl/rv32i_regfile_rdport.sv | 29 ++
 rtl/rv32i_regfile.sv | 62 ++++++
 tb/tb_rv32i_regfile.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared widths and index/data types for the RV32I register file
package rv32i_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  typedef logic [XLEN-1:0] xlen_t;
  typedef logic [AW-1:0]   reg_idx_t;

endpackage

// File: rtl/rv32i_regfile_rdport.sv
// rtl/rv32i_regfile_rdport.sv - one combinational read port with x0 zeroing
// REGFILE_BYPASS_EN adds same-cycle write-through forwarding.
module regfile_rdport
  import rv32i_pkg::*;
(
  input  reg_idx_t addr,
  input  xlen_t    regs [NREGS],
`ifdef REGFILE_BYPASS_EN
  input  logic     fwd_en,
  input  reg_idx_t waddr,
  input  xlen_t    wdata,
`endif
  output xlen_t    res
);

  always_comb begin
    res = regs[addr];
`ifdef REGFILE_BYPASS_EN
    // fwd_en is already qualified with reset and waddr!=0 by the top
    if (fwd_en && (addr == waddr)) begin
      res = wdata;
    end
`endif
    if (addr == '0) begin
      res = '0;
    end
  end

endmodule

// File: rtl/rv32i_regfile.sv
// rtl/rv32i_regfile.sv - 32x32 RV32I register file, 2 read ports, 1 write port
// Optional write-through forwarding when REGFILE_BYPASS_EN is defined.
module rv32i_regfile
  import rv32i_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  reg_idx_t waddr,
  input  reg_idx_t addr1,
  input  reg_idx_t addr2,
  input  xlen_t    wdata,
  input  logic     regwen,
  output xlen_t    res1,
  output xlen_t    res2
);

  xlen_t rs [0:NREGS-1];
  logic  wr_en;

  always_comb begin
    wr_en = rst && regwen && (waddr != '0);
  end

  // rs[0] is only ever cleared, so it stays zero without a read-side special case
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rs[i] <= '0;
      end
    end else if (wr_en) begin
      rs[waddr] <= wdata;
    end
  end

  regfile_rdport u_rdport1 (
    .addr   (addr1),
    .regs   (rs),
`ifdef REGFILE_BYPASS_EN
    .fwd_en (wr_en),
    .waddr  (waddr),
    .wdata  (wdata),
`endif
    .res    (res1)
  );

  regfile_rdport u_rdport2 (
    .addr   (addr2),
    .regs   (rs),
`ifdef REGFILE_BYPASS_EN
    .fwd_en (wr_en),
    .waddr  (waddr),
    .wdata  (wdata),
`endif
    .res    (res2)
  );

`ifndef SYNTHESIS
  a_x0_zero : assert property (@(posedge clk) rst |-> (rs[0] == '0));
  a_aw_exact : assert property (@(posedge clk) AW == $clog2(NREGS));
`endif

endmodule

// File: tb/tb_rv32i_regfile.sv
// tb/tb_rv32i_regfile.sv - vector table plus scoreboarded random traffic for rv32i_regfile
module tb_rv32i_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  waddr, addr1, addr2;
  logic [31:0] wdata;
  logic        regwen;
  logic [31:0] res1, res2;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [32];
  logic [31:0] exp_q [$];

  typedef struct {
    logic        rstn;
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [7];

  rv32i_regfile dut (
    .clk    (clk),
    .rst    (rst),
    .waddr  (waddr),
    .addr1  (addr1),
    .addr2  (addr2),
    .wdata  (wdata),
    .regwen (regwen),
    .res1   (res1),
    .res2   (res2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic pop_check(input string name, input logic [31:0] got);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", name, got);
    end else begin
      e = exp_q.pop_front();
      check(name, got, e);
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    rst = 1'b1; regwen = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    regwen = 1'b0;
    if (a != 5'd0) model[a] = d;
  endtask

  initial begin
    rst = 1'b0; regwen = 1'b0; waddr = '0; wdata = '0; addr1 = '0; addr2 = '0;

    vecs[0] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd15, 5'd31, 32'h0,        32'h0};
    vecs[1] = '{1'b1, 1'b1, 5'd15, 32'hABCDEFAA, 5'd15, 5'd31, 32'hABCDEFAA, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[3] = '{1'b1, 1'b0, 5'd7,  32'h12345678, 5'd7,  5'd15, 32'h0,        32'hABCDEFAA};
    vecs[4] = '{1'b1, 1'b1, 5'd31, 32'h80000001, 5'd31, 5'd31, 32'h80000001, 32'h80000001};
    vecs[5] = '{1'b1, 1'b1, 5'd15, 32'h00000001, 5'd15, 5'd7,  32'h00000001, 32'h0};
    vecs[6] = '{1'b0, 1'b1, 5'd15, 32'h00000005, 5'd15, 5'd31, 32'h0,        32'h0};

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      rst = vecs[i].rstn; regwen = vecs[i].wen; waddr = vecs[i].wa; wdata = vecs[i].wd;
      addr1 = vecs[i].a1; addr2 = vecs[i].a2;
      exp_q.push_back(vecs[i].e1);
      exp_q.push_back(vecs[i].e2);
      @(posedge clk);
      #1;
      pop_check($sformatf("vec%0d_res1", i), res1);
      pop_check($sformatf("vec%0d_res2", i), res2);
      if (i == 0 || i == 6) begin
        for (int r = 0; r < 32; r++) begin
          check($sformatf("vec%0d_rs%0d_reset", i, r), dut.rs[r], 32'h0);
        end
      end
      if (i == 2) check("x0_after_write", dut.rs[0], 32'h0);
      if (i == 3) check("rs7_regwen0", dut.rs[7], 32'h0);
    end

    @(negedge clk);
    regwen = 1'b0;
    for (int r = 0; r < 32; r++) model[r] = 32'h0;

    for (int n = 0; n < 100; n++) begin
      write_reg(5'($urandom_range(0, 31)), $urandom);
      waddr = 5'($urandom_range(0, 31));
      wdata = $urandom;
    end

    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      addr1 = 5'($urandom_range(0, 31));
      addr2 = (n % 10 == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      exp_q.push_back(model[addr1]);
      exp_q.push_back(model[addr2]);
      #1;
      pop_check($sformatf("rand%0d_res1_a%0d", n, addr1), res1);
      pop_check($sformatf("rand%0d_res2_a%0d", n, addr2), res2);
    end

    write_reg(5'd9, 32'h11110009);
    @(negedge clk);
    addr1 = 5'd9; addr2 = 5'd9; waddr = 5'd9; wdata = 32'hDEAD0009; regwen = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("rdw_before_edge", res1, 32'hDEAD0009);
`else
    check("rdw_before_edge", res1, 32'h11110009);
`endif
    @(posedge clk);
    #1;
    check("rdw_after_edge_res1", res1, 32'hDEAD0009);
    check("rdw_after_edge_res2", res2, 32'hDEAD0009);
    check("rdw_rs9", dut.rs[9], 32'hDEAD0009);
    @(negedge clk);
    regwen = 1'b0;

    write_reg(5'd3, 32'h0BADF00D);
    check("x3_written", dut.rs[3], 32'h0BADF00D);
    @(negedge clk);
    rst = 1'b0; regwen = 1'b1; waddr = 5'd3; wdata = 32'h5; addr1 = 5'd3; addr2 = 5'd9;
    @(posedge clk);
    #1;
    check("reset_wins_rs3", dut.rs[3], 32'h0);
    check("reset_wins_res1", res1, 32'h0);
    check("reset_wins_res2", res2, 32'h0);
    @(negedge clk);
    rst = 1'b1; regwen = 1'b0;

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
